// File: rtl/uart_msg_sequencer.sv
// Streams a writable message table into a UART transmitter over a valid/busy
// handshake, with single-shot, counted-repeat and free-running modes plus gaps.
module uart_msg_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int GAP_W  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [PTR_W-1:0]  wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [PTR_W:0]    msgLen,
    input  logic [7:0]        repeatCount,
    input  logic [GAP_W-1:0]  gapCycles,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] txData,
    output logic              txValid,
    input  logic              txBusy,
    output logic              active,
    output logic              done,
    output logic [15:0]       sentCount
);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, GAP} state_t;

    localparam logic [PTR_W:0] DEPTH_LEN = (PTR_W + 1)'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W:0]    len_lat;
    logic [PTR_W:0]    len_clamped;
    logic [PTR_W:0]    ptr_next;
    logic [7:0]        rep_lat;
    logic [7:0]        pass;
    logic [7:0]        pass_next;
    logic [GAP_W-1:0]  gap_lat;
    logic [GAP_W-1:0]  gap_cnt;
    logic              stop_pending;
    logic              boundary;
    logic              wrap;
    logic              finish;

    // Table survives reset so a message can be preloaded once and replayed.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // A zero gap skips the GAP state so the next byte follows busy falling by two cycles.
    always_comb begin
        len_clamped = (msgLen > DEPTH_LEN) ? DEPTH_LEN : msgLen;
        ptr_next    = {1'b0, ptr} + (PTR_W + 1)'(1);
        wrap        = (ptr_next == len_lat);
        pass_next   = pass + 8'd1;
        boundary    = ((state == WAIT_LO) && !txBusy && (gap_lat == '0)) ||
                      ((state == GAP) && (gap_cnt == gap_lat));
        finish      = stop_pending || stop ||
                      (wrap && (rep_lat != 8'd0) && (pass_next == rep_lat));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            txData       <= '0;
            txValid      <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b0;
            sentCount    <= '0;
            stop_pending <= 1'b0;
            ptr          <= '0;
            pass         <= '0;
            len_lat      <= '0;
            rep_lat      <= '0;
            gap_lat      <= '0;
            gap_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop) begin
                stop_pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_lat      <= len_clamped;
                        rep_lat      <= repeatCount;
                        gap_lat      <= gapCycles;
                        ptr          <= '0;
                        pass         <= '0;
                        stop_pending <= 1'b0;
                        if (len_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            state  <= LOAD;
                            active <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    txData  <= mem[ptr];
                    txValid <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (!txBusy) begin
                        txValid   <= 1'b0;
                        sentCount <= sentCount + 16'd1;
                        state     <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (txBusy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!txBusy && gap_lat != '0) begin
                        gap_cnt <= GAP_W'(1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt != gap_lat) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Byte boundary: advance the pointer, then either end or fetch the next byte.
            if (boundary) begin
                ptr <= wrap ? '0 : ptr_next[PTR_W-1:0];
                if (wrap) begin
                    pass <= pass_next;
                end
                if (finish) begin
                    state        <= IDLE;
                    active       <= 1'b0;
                    done         <= 1'b1;
                    stop_pending <= 1'b0;
                end else begin
                    state <= LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench for uart_msg_sequencer: table-driven sequences against a
// simple busy-for-N-cycles UART model, plus hand-written hold/stop/reset cases.
module tb_uart_msg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [7:0]  wrData;
    logic [4:0]  msgLen;
    logic [7:0]  repeatCount;
    logic [15:0] gapCycles;
    logic        start;
    logic        stop;
    logic [7:0]  txData;
    logic        txValid;
    logic        txBusy;
    logic        active;
    logic        done;
    logic [15:0] sentCount;

    uart_msg_sequencer #(.DATA_W(8), .DEPTH(16), .GAP_W(16)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .msgLen(msgLen), .repeatCount(repeatCount), .gapCycles(gapCycles),
        .start(start), .stop(stop), .txData(txData), .txValid(txValid),
        .txBusy(txBusy), .active(active), .done(done), .sentCount(sentCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int msg_len;
        int rep;
        int gap;
        int busy;
        int start_stop;
        int exp_len;
        int exp_passes;
    } row_t;

    row_t       rows [6];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         busy_left = 0;
    int         busy_len = 1;
    bit         hold_busy = 1'b0;
    logic [7:0] tb_mem [16];
    logic [7:0] got [$];
    int         fall_cyc = -1;
    int         spacing_exp = 2;
    int         spacing_err = 0;
    int         overlap = 0;
    int         done_cnt = 0;
    int         done_active_bad = 0;
    int         exp_sent = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: UART model captures accepted bytes and drives busy for busy_len cycles.
    task automatic tick();
        logic       pre_acc;
        logic       pre_valid;
        logic       prev_busy;
        logic [7:0] pre_data;
        pre_acc   = (txValid === 1'b1) && (txBusy === 1'b0);
        pre_valid = txValid;
        pre_data  = txData;
        prev_busy = txBusy;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        stop  = 1'b0;
        if (pre_acc) begin
            got.push_back(pre_data);
            busy_left = busy_len;
        end
        if (hold_busy || busy_left > 0) begin
            txBusy = 1'b1;
            if (busy_left > 0) busy_left--;
        end else begin
            txBusy = 1'b0;
        end
        if (prev_busy === 1'b1 && txBusy === 1'b0) fall_cyc = cyc;
        if (pre_valid === 1'b0 && txValid === 1'b1 && fall_cyc >= 0) begin
            if (cyc - fall_cyc != spacing_exp) spacing_err++;
            fall_cyc = -1;
        end
        if (txValid === 1'b1 && txBusy === 1'b1) overlap++;
        if (done === 1'b1) begin
            done_cnt++;
            if (active !== 1'b0) done_active_bad++;
        end
    endtask

    task automatic writeEntry(input int addr, input logic [7:0] data);
        wrEn   = 1'b1;
        wrAddr = 4'(addr);
        wrData = data;
        tb_mem[addr] = data;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic clearScenario();
        got.delete();
        fall_cyc        = -1;
        spacing_err     = 0;
        overlap         = 0;
        done_cnt        = 0;
        done_active_bad = 0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            tick();
            n++;
        end
        checkOutput("done_seen", done_cnt != 0, 1);
    endtask

    task automatic applyStimulus(input row_t r);
        int bad = 0;
        clearScenario();
        busy_len    = r.busy;
        spacing_exp = r.gap + 2;
        msgLen      = 5'(r.msg_len);
        repeatCount = 8'(r.rep);
        gapCycles   = 16'(r.gap);
        start       = 1'b1;
        stop        = (r.start_stop != 0);
        tick();
        checkOutput("active_after_start", active, r.exp_len != 0);
        checkOutput("done_after_start", done, r.exp_len == 0);
        if (r.exp_len != 0) begin
            tick();
            checkOutput("first_valid", txValid, 1);
            checkOutput("first_data", txData, tb_mem[0]);
        end
        waitDone();
        repeat (8) tick();
        checkOutput("byte_count", got.size(), r.exp_len * r.exp_passes);
        foreach (got[i]) begin
            if (got[i] !== tb_mem[i % r.exp_len]) bad++;
        end
        checkOutput("byte_values", bad, 0);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("active_at_done", done_active_bad, 0);
        checkOutput("spacing", spacing_err, 0);
        checkOutput("valid_during_busy", overlap, 0);
        exp_sent += r.exp_len * r.exp_passes;
        checkOutput("sent_count", sentCount, exp_sent);
    endtask

    initial begin
        int         n;
        int         changes;
        logic [7:0] data0;

        rows[0] = '{msg_len: 2,  rep: 1, gap: 0, busy: 10, start_stop: 0, exp_len: 2,  exp_passes: 1};
        rows[1] = '{msg_len: 3,  rep: 2, gap: 5, busy: 4,  start_stop: 0, exp_len: 3,  exp_passes: 2};
        rows[2] = '{msg_len: 0,  rep: 1, gap: 0, busy: 1,  start_stop: 0, exp_len: 0,  exp_passes: 1};
        rows[3] = '{msg_len: 21, rep: 1, gap: 0, busy: 2,  start_stop: 0, exp_len: 16, exp_passes: 1};
        rows[4] = '{msg_len: 2,  rep: 1, gap: 0, busy: 2,  start_stop: 1, exp_len: 2,  exp_passes: 1};
        rows[5] = '{msg_len: 1,  rep: 3, gap: 1, busy: 1,  start_stop: 0, exp_len: 1,  exp_passes: 3};

        rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; msgLen = '0;
        repeatCount = '0; gapCycles = '0; start = 1'b0; stop = 1'b0; txBusy = 1'b0;
        repeat (3) tick();
        checkOutput("reset_txData", txData, 0);
        checkOutput("reset_txValid", txValid, 0);
        checkOutput("reset_active", active, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sentCount", sentCount, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            writeEntry(i, (i == 0) ? 8'h11 : (i == 1) ? 8'h0A : 8'(8'h30 + i));
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(rows[i]);
        end

        // UART stays busy through SEND: the offered byte must hold without being taken.
        clearScenario();
        busy_len = 3; hold_busy = 1'b1; txBusy = 1'b1;
        msgLen = 5'd1; repeatCount = 8'd1; gapCycles = 16'd0; start = 1'b1;
        tick();
        tick();
        data0 = txData;
        checkOutput("hold_initial_data", data0, tb_mem[0]);
        changes = 0;
        repeat (50) begin
            tick();
            if (txValid !== 1'b1 || txData !== data0) changes++;
        end
        checkOutput("hold_stable", changes, 0);
        checkOutput("hold_no_accept", got.size(), 0);
        hold_busy = 1'b0;
        waitDone();
        checkOutput("hold_one_byte", got.size(), 1);
        exp_sent += 1;
        checkOutput("hold_sent_count", sentCount, exp_sent);

        // Free-running loop stopped while the 5th byte is being offered.
        clearScenario();
        busy_len = 3; spacing_exp = 3;
        msgLen = 5'd3; repeatCount = 8'd0; gapCycles = 16'd1; start = 1'b1;
        tick();
        n = 0;
        while (got.size() < 4 && n < 4000) begin tick(); n++; end
        while (txValid !== 1'b1 && n < 4000) begin tick(); n++; end
        checkOutput("stop_setup", got.size(), 4);
        stop = 1'b1;
        tick();
        waitDone();
        changes = 0;
        repeat (10) begin
            tick();
            if (txValid !== 1'b0) changes++;
        end
        checkOutput("stop_byte_count", got.size(), 5);
        checkOutput("stop_last_byte", (got.size() == 5) ? got[4] : 8'hxx, tb_mem[1]);
        checkOutput("stop_done_pulses", done_cnt, 1);
        checkOutput("stop_no_more_valid", changes, 0);
        exp_sent += 5;
        checkOutput("stop_sent_count", sentCount, exp_sent);

        // Reset while a byte is offered, then restart from table[0].
        clearScenario();
        hold_busy = 1'b1; txBusy = 1'b1;
        msgLen = 5'd4; repeatCount = 8'd1; gapCycles = 16'd0; start = 1'b1;
        tick();
        tick();
        checkOutput("rst_pre_valid", txValid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_txValid", txValid, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_txData", txData, 0);
        checkOutput("rst_sentCount", sentCount, 0);
        checkOutput("rst_done", done, 0);
        hold_busy = 1'b0; busy_left = 0;
        tick();
        exp_sent = 0;
        applyStimulus(rows[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
